// File: rtl/axis_red_pitaya_adc_mc_if.sv
// AXI4-Stream beat bus (valid/ready/data) carrying the packed per-channel ADC results.
interface axis_red_pitaya_adc_mc_if #(
    parameter int TDATA_WIDTH = 32
);
    logic                   tvalid;
    logic                   tready;
    logic [TDATA_WIDTH-1:0] tdata;

    modport master (output tvalid, output tdata, input tready);
    modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/axis_red_pitaya_adc_mc.sv
// Multi-channel ADC capture: input register, offset-binary to two's complement, 2^L boxcar average,
// single-entry AXIS output register with overflow count. ADC_TEST_PATTERN_EN adds a ramp test source.
module axis_red_pitaya_adc_mc #(
    parameter int NUM_CH           = 2,
    parameter int ADC_DATA_WIDTH   = 14,
    parameter int AXIS_TDATA_WIDTH = 16,
    parameter int MAX_LOG2_DECIM   = 4,
    parameter int OVF_CNT_WIDTH    = 16
) (
    input  logic                               int_clk,
    input  logic                               areset,
    output logic                               adc_csn,
    input  logic [NUM_CH*ADC_DATA_WIDTH-1:0]   adc_dat,
    input  logic                               cfg_enable,
    input  logic [2:0]                         cfg_log2_decim,
`ifdef ADC_TEST_PATTERN_EN
    input  logic                               cfg_test_pattern,
`endif
    axis_red_pitaya_adc_mc_if.master           m_axis,
    output logic [OVF_CNT_WIDTH-1:0]           sts_overflow_cnt
);
    localparam int W   = ADC_DATA_WIDTH;
    localparam int TW  = AXIS_TDATA_WIDTH;
    localparam int AW  = W + MAX_LOG2_DECIM;
    localparam int CW  = (MAX_LOG2_DECIM > 0) ? MAX_LOG2_DECIM : 1;
    localparam int CW1 = CW + 1;

    function automatic logic [W-1:0] conv_code(input logic [W-1:0] raw);
        return {raw[W-1], ~raw[W-2:0]};
    endfunction

    logic [NUM_CH*W-1:0]       adc_r;
    logic                      en_r;
    logic signed [W-1:0]       conv_s [NUM_CH];
    logic signed [AW-1:0]      acc_r  [NUM_CH];
    logic signed [AW-1:0]      sum_s  [NUM_CH];
    logic [NUM_CH*TW-1:0]      res_s;
    logic [NUM_CH*TW-1:0]      res_r;
    logic                      res_vld_r;
    logic [CW-1:0]             count_r;
    logic [CW:0]               cnt_inc_s;
    logic                      last_s;
    logic [2:0]                l_r;
    logic [2:0]                l_cfg_s;
    logic [2:0]                l_eff_s;
    logic                      tvalid_r;
    logic [NUM_CH*TW-1:0]      tdata_r;
    logic [OVF_CNT_WIDTH-1:0]  ovf_r;

    assign adc_csn          = 1'b1;
    assign m_axis.tvalid    = tvalid_r;
    assign m_axis.tdata     = tdata_r;
    assign sts_overflow_cnt = ovf_r;

    // Stage 1: register the ADC pins together with the enable that qualifies them
    always_ff @(posedge int_clk or posedge areset) begin
        if (areset) begin
            adc_r <= {(NUM_CH*W){1'b0}};
            en_r  <= 1'b0;
        end else begin
            adc_r <= adc_dat;
            en_r  <= cfg_enable;
        end
    end

`ifdef ADC_TEST_PATTERN_EN
    logic [W-1:0] ramp_r;

    // Free-running ramp used as the test source
    always_ff @(posedge int_clk or posedge areset) begin
        if (areset) begin
            ramp_r <= {W{1'b0}};
        end else begin
            ramp_r <= ramp_r + W'(1);
        end
    end
`endif

    // Per-channel sample source: raw code converted to two's complement, or the ramp
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
`ifdef ADC_TEST_PATTERN_EN
            if (cfg_test_pattern) begin
                conv_s[c] = ramp_r + W'(c);
            end else begin
                conv_s[c] = conv_code(adc_r[c*W +: W]);
            end
`else
            conv_s[c] = conv_code(adc_r[c*W +: W]);
`endif
        end
    end

    // Decimation control and accumulate/average datapath; L only changes at block start
    always_comb begin
        l_cfg_s   = (cfg_log2_decim > 3'(MAX_LOG2_DECIM)) ? 3'(MAX_LOG2_DECIM) : cfg_log2_decim;
        l_eff_s   = (count_r == {CW{1'b0}}) ? l_cfg_s : l_r;
        cnt_inc_s = {1'b0, count_r} + CW1'(1);
        last_s    = ((cnt_inc_s >> l_eff_s) != {CW1{1'b0}});
        for (int c = 0; c < NUM_CH; c++) begin
            if (count_r == {CW{1'b0}}) begin
                sum_s[c] = AW'(conv_s[c]);
            end else begin
                sum_s[c] = acc_r[c] + AW'(conv_s[c]);
            end
            res_s[c*TW +: TW] = TW'($signed(W'(sum_s[c] >>> l_eff_s)));
        end
    end

    // Stage 2: accumulators, block counter and the one-cycle result strobe
    always_ff @(posedge int_clk or posedge areset) begin
        if (areset) begin
            count_r   <= {CW{1'b0}};
            l_r       <= 3'd0;
            res_r     <= {(NUM_CH*TW){1'b0}};
            res_vld_r <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) acc_r[c] <= {AW{1'b0}};
        end else if (!en_r) begin
            count_r   <= {CW{1'b0}};
            res_vld_r <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) acc_r[c] <= {AW{1'b0}};
        end else begin
            res_vld_r <= last_s;
            if (count_r == {CW{1'b0}}) begin
                l_r <= l_cfg_s;
            end
            if (last_s) begin
                count_r <= {CW{1'b0}};
                res_r   <= res_s;
            end else begin
                count_r <= cnt_inc_s[CW-1:0];
            end
            for (int c = 0; c < NUM_CH; c++) acc_r[c] <= sum_s[c];
        end
    end

    // Output register: a result arriving while a beat is stalled is dropped and counted
    always_ff @(posedge int_clk or posedge areset) begin
        if (areset) begin
            tvalid_r <= 1'b0;
            tdata_r  <= {(NUM_CH*TW){1'b0}};
            ovf_r    <= {OVF_CNT_WIDTH{1'b0}};
        end else if (res_vld_r) begin
            if (!tvalid_r || m_axis.tready) begin
                tdata_r  <= res_r;
                tvalid_r <= 1'b1;
            end else if (ovf_r != {OVF_CNT_WIDTH{1'b1}}) begin
                ovf_r <= ovf_r + OVF_CNT_WIDTH'(1);
            end
        end else if (m_axis.tready) begin
            tvalid_r <= 1'b0;
        end
    end
endmodule

// File: tb/tb_axis_red_pitaya_adc_mc.sv
// Scoreboard bench for axis_red_pitaya_adc_mc: directed vectors push expected beats, a monitor pops on transfer.
module tb_axis_red_pitaya_adc_mc;
    logic        int_clk = 1'b0;
    logic        areset;
    logic [27:0] adc_dat;
    logic        cfg_enable, cfg_enable_b;
    logic [2:0]  cfg_log2_decim;
    logic        csn_a, csn_b;
    logic [15:0] ovf_a;
    logic [3:0]  ovf_b;
`ifdef ADC_TEST_PATTERN_EN
    logic        cfg_test_pattern;
`endif

    always #5 int_clk = ~int_clk;

    axis_red_pitaya_adc_mc_if #(.TDATA_WIDTH(32)) axis_a ();
    axis_red_pitaya_adc_mc_if #(.TDATA_WIDTH(32)) axis_b ();

    axis_red_pitaya_adc_mc dut_a (
        .int_clk(int_clk), .areset(areset), .adc_csn(csn_a), .adc_dat(adc_dat),
        .cfg_enable(cfg_enable), .cfg_log2_decim(cfg_log2_decim),
`ifdef ADC_TEST_PATTERN_EN
        .cfg_test_pattern(cfg_test_pattern),
`endif
        .m_axis(axis_a), .sts_overflow_cnt(ovf_a)
    );

    axis_red_pitaya_adc_mc #(.OVF_CNT_WIDTH(4)) dut_b (
        .int_clk(int_clk), .areset(areset), .adc_csn(csn_b), .adc_dat(adc_dat),
        .cfg_enable(cfg_enable_b), .cfg_log2_decim(cfg_log2_decim),
`ifdef ADC_TEST_PATTERN_EN
        .cfg_test_pattern(cfg_test_pattern),
`endif
        .m_axis(axis_b), .sts_overflow_cnt(ovf_b)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    bit          tp_mode = 1'b0;
    int          tp_beats = 0;
    int          tp_wraps = 0;
    logic [15:0] tp_prev;

    logic [13:0] t_c0 [4]  = '{14'h0000, 14'h3FFF, 14'h2000, 14'h1F9B};
    logic [13:0] t_c1 [4]  = '{14'h3FFF, 14'h0000, 14'h1FFF, 14'h2063};
    logic [31:0] t_exp [4] = '{32'hE000_1FFF, 32'h1FFF_E000, 32'h0000_FFFF, 32'hFF9C_0064};

    logic [13:0] b_c0 [16] = '{14'h1F9B, 14'h1F9B, 14'h1F9B, 14'h1F9B, 14'h1F9B, 14'h1F37, 14'h1ED3, 14'h1E6F,
                               14'h1FFE, 14'h1FFF, 14'h1FFF, 14'h1FFF, 14'h0000, 14'h0000, 14'h0000, 14'h0000};
    logic [13:0] b_c1 [16] = '{14'h2063, 14'h2063, 14'h2063, 14'h2063, 14'h2000, 14'h2000, 14'h2000, 14'h2000,
                               14'h2000, 14'h1FFF, 14'h1FFF, 14'h1FFF, 14'h3FFF, 14'h3FFF, 14'h3FFF, 14'h3FFF};
    logic [31:0] b_exp [4] = '{32'hFF9C_0064, 32'hFFFF_00FA, 32'hFFFF_0000, 32'hE000_1FFF};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [13:0] c0, input logic [13:0] c1, input bit push, input logic [31:0] exp);
        adc_dat = {c1, c0};
        if (push) exp_q.push_back(exp);
        @(posedge int_clk);
        #1;
    endtask

    task automatic drain(input string name);
        repeat (5) @(posedge int_clk);
        #1;
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: every transfer on dut_a is compared against the next expected beat
    always @(negedge int_clk) begin
        if (!areset && axis_a.tvalid && axis_a.tready) begin
            if (tp_mode) begin
                logic [13:0] diff;
                logic [13:0] nxt;
                diff = axis_a.tdata[29:16] - axis_a.tdata[13:0];
                check("tp_lane_diff", {18'd0, diff}, 32'd1);
                if (tp_beats > 0) begin
                    nxt = tp_prev[13:0] + 14'd1;
                    check("tp_step", {16'd0, axis_a.tdata[15:0]}, {16'd0, {2{nxt[13]}}, nxt});
                    if (tp_prev == 16'h1FFF) tp_wraps++;
                end
                tp_prev = axis_a.tdata[15:0];
                tp_beats++;
            end else if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got %h expected no beat", axis_a.tdata);
            end else begin
                check("beat", axis_a.tdata, exp_q.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int rise;
        areset = 1'b1; adc_dat = 28'd0; cfg_enable = 1'b0; cfg_enable_b = 1'b0; cfg_log2_decim = 3'd0;
        axis_a.tready = 1'b1; axis_b.tready = 1'b0;
`ifdef ADC_TEST_PATTERN_EN
        cfg_test_pattern = 1'b0;
`endif
        repeat (3) @(posedge int_clk);
        @(negedge int_clk);
        check("rst_tvalid", {31'd0, axis_a.tvalid}, 32'd0);
        check("rst_tdata", axis_a.tdata, 32'd0);
        check("rst_ovf", {16'd0, ovf_a}, 32'd0);
        check("adc_csn", {31'd0, csn_a}, 32'd1);
        areset = 1'b0;
        @(posedge int_clk); #1;

        // L=0, one beat per sample
        cfg_enable = 1'b1;
        for (int i = 0; i < 4; i++) drive(t_c0[i], t_c1[i], 1'b1, t_exp[i]);
        cfg_enable = 1'b0;
        drain("drain_l0");

        // L=0 latency: sample at edge n appears after edge n+2
        cfg_enable = 1'b1;
        drive(14'h0000, 14'h3FFF, 1'b1, 32'hE000_1FFF);
        cfg_enable = 1'b0;
        @(negedge int_clk); check("lat_n0", {31'd0, axis_a.tvalid}, 32'd0);
        @(negedge int_clk); check("lat_n1", {31'd0, axis_a.tvalid}, 32'd0);
        @(negedge int_clk); check("lat_n2", {31'd0, axis_a.tvalid}, 32'd1);
        @(negedge int_clk); check("lat_n3_fall", {31'd0, axis_a.tvalid}, 32'd0);
        drain("drain_lat");

        // L=2 blocks
        cfg_log2_decim = 3'd2;
        cfg_enable = 1'b1;
        for (int i = 0; i < 16; i++) drive(b_c0[i], b_c1[i], (i % 4) == 3, b_exp[i / 4]);
        cfg_enable = 1'b0;
        drain("drain_l2");

        // L change mid-block takes effect next block
        cfg_enable = 1'b1;
        drive(14'h1FFB, 14'h1FFF, 1'b0, 32'd0);
        drive(14'h1FF7, 14'h1FFF, 1'b0, 32'd0);
        cfg_log2_decim = 3'd0;
        drive(14'h1FF3, 14'h1FFF, 1'b0, 32'd0);
        drive(14'h1FEF, 14'h1FFF, 1'b1, 32'h0000_000A);
        cfg_enable = 1'b0;
        drain("drain_midL");

        // L=7 clamps to 4: one beat per 16 samples
        cfg_log2_decim = 3'd7;
        cfg_enable = 1'b1;
        for (int i = 0; i < 16; i++) drive(14'h1FFA, 14'h2002, i == 15, 32'hFFFD_0005);
        cfg_enable = 1'b0;
        drain("drain_clamp");

        // Backpressure: first beat held, ten results dropped
        cfg_log2_decim = 3'd0;
        axis_a.tready = 1'b0;
        cfg_enable = 1'b1;
        for (int k = 1; k <= 11; k++) drive(14'(k), 14'(16'h3FFF - k), k == 1, 32'hE001_1FFE);
        cfg_enable = 1'b0;
        repeat (2) @(posedge int_clk);
        #1;
        check("ovf_10", {16'd0, ovf_a}, 32'd10);
        check("stall_tvalid", {31'd0, axis_a.tvalid}, 32'd1);
        check("stall_tdata", axis_a.tdata, 32'hE001_1FFE);
        axis_a.tready = 1'b1;
        @(negedge int_clk);
        @(negedge int_clk);
        check("post_release_tvalid", {31'd0, axis_a.tvalid}, 32'd0);
        drain("drain_bp");

        // 4-bit overflow counter saturates
        cfg_enable_b = 1'b1;
        for (int k = 1; k <= 16; k++) drive(14'(k), 14'(16'h3FFF - k), 1'b0, 32'd0);
        repeat (2) @(posedge int_clk);
        #1;
        check("ovf_b_15", {28'd0, ovf_b}, 32'hF);
        for (int k = 0; k < 5; k++) drive(14'h0100, 14'h0100, 1'b0, 32'd0);
        cfg_enable_b = 1'b0;
        repeat (3) @(posedge int_clk);
        #1;
        check("ovf_b_sat", {28'd0, ovf_b}, 32'hF);
        check("b_tvalid", {31'd0, axis_b.tvalid}, 32'd1);
        check("b_tdata", axis_b.tdata, 32'hE001_1FFE);

        // Reset at count 5 of an L=3 block
        cfg_log2_decim = 3'd3;
        cfg_enable = 1'b1;
        for (int i = 0; i < 6; i++) drive(14'h0000, 14'h3FFF, 1'b0, 32'd0);
        areset = 1'b1;
        #1;
        check("rst_mid_tvalid", {31'd0, axis_a.tvalid}, 32'd0);
        check("rst_mid_ovf", {16'd0, ovf_a}, 32'd0);
        adc_dat = {14'h2063, 14'h1F9B};
        exp_q.push_back(32'hFF9C_0064);
        @(negedge int_clk);
        areset = 1'b0;
        rise = 0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(posedge int_clk);
            #1;
            if (cyc == 8) cfg_enable = 1'b0;
            @(negedge int_clk);
            if (axis_a.tvalid && rise == 0) rise = cyc;
        end
        check("rst_next_beat_cycle", 32'(rise), 32'd10);
        drain("drain_rst");

`ifdef ADC_TEST_PATTERN_EN
        // Ramp test pattern through L=0
        cfg_log2_decim = 3'd0;
        tp_mode = 1'b1;
        cfg_test_pattern = 1'b1;
        cfg_enable = 1'b1;
        repeat (16500) @(posedge int_clk);
        #1;
        cfg_enable = 1'b0;
        repeat (5) @(posedge int_clk);
        #1;
        tp_mode = 1'b0;
        cfg_test_pattern = 1'b0;
        check("tp_wrap_seen", {31'd0, tp_wraps > 0}, 32'd1);
        check("tp_beats", {31'd0, tp_beats >= 16500}, 32'd1);
`endif

        check("queue_empty_end", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
